// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data memory responder:
//   - access size encodings
//   - responder FSM state enum
//   - byte-enable, store-lane replication and load extraction helpers
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // Lanes written by a store of the given size at byte offset a.
    function automatic logic [3:0] dmem_byte_en(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << a;
            SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data arrives right-aligned; copy it into every lane so the byte
    // enables alone pick the destination.
    function automatic logic [31:0] dmem_store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {4{wdata[7:0]}};
            SZ_HALF: d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Misalignment and reserved-size faults (range is checked by the caller).
    function automatic logic dmem_bad_align(input logic [1:0] size, input logic [1:0] a);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = a[0];
            SZ_WORD: bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Pull the addressed lane(s) out of a RAM word and extend to 32 bits.
    function automatic logic [31:0] dmem_load(input logic [1:0] size, input logic uns,
                                              input logic [1:0] a, input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {a, 3'b000};
        case (size)
            SZ_BYTE: res = uns ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: res = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
// Load/store data bus between the core (master/initiator) and the data memory
// responder (slave).
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; request fields are only meaningful in that cycle.
// resp_valid is a one-cycle pulse; resp_rdata/resp_err are valid with it.
//
// Signals: req_valid, req_ready, req_we, req_size[1:0], req_unsigned,
//          req_addr[31:0], req_wdata[31:0], resp_valid, resp_rdata[31:0],
//          resp_err.
// -----------------------------------------------------------------------------
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder_byte_ram.sv
// -----------------------------------------------------------------------------
// dmem_byte_ram
// DEPTH x 32 single-port RAM with per-byte write enables and a registered
// (synchronous) read. On an enabled cycle the read returns the contents before
// any write of that same edge.
// Ports:
//   clk       clock
//   i_en      access enable
//   i_we      byte write enables (lane 0 = bits 7:0)
//   i_addr    word index
//   i_wdata   write data (already lane-replicated)
//   o_rdata   read data, valid the cycle after an enabled access
// -----------------------------------------------------------------------------
module dmem_byte_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Target end of the core's load/store data interface. Services one request at
// a time from a word-organised RAM at BASE_ADDR, inserting LATENCY wait
// states, with byte/half/word accesses, sign/zero extension and fault
// detection (reserved size, misalignment, out of range).
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   bus       data bus, slave side (see data_mem_responder_if)
//   o_state   current FSM state (debug)
// -----------------------------------------------------------------------------
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus,
    output dmem_state_e          o_state
);
    localparam int          AW       = $clog2(DEPTH);
    localparam bit          LAT_ZERO = (LATENCY == 0);
    localparam logic [3:0]  LAT_LOAD = 4'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic [32:0] LO_LIM   = {1'b0, BASE_ADDR};
    localparam logic [32:0] HI_LIM   = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

    dmem_state_e r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic        r_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic        w_accept;
    logic        w_go_resp;
    logic        w_src_we;
    logic [1:0]  w_src_size;
    logic [31:0] w_src_addr;
    logic [31:0] w_src_wdata;
    logic [32:0] w_addr33;
    logic        w_in_range;
    logic        w_fault;
    logic [31:0] w_offset;
    logic [AW-1:0] w_index;
    logic [3:0]  w_ram_we;
    logic [31:0] w_ram_wdata;
    logic [31:0] w_ram_rdata;

    // r_ready is only ever set while IDLE, so it alone qualifies the accept.
    assign w_accept = bus.req_valid & r_ready & ~reset;

    // The RAM is accessed on the edge that enters RESP. With no wait states
    // that is the accept edge itself, so the live request is used then;
    // otherwise the captured copy is.
    assign w_go_resp = ((r_state == ST_IDLE) && w_accept && LAT_ZERO) ||
                       ((r_state == ST_WAIT) && (r_cnt == 4'd0));

    assign w_src_we    = (r_state == ST_IDLE) ? bus.req_we    : r_we;
    assign w_src_size  = (r_state == ST_IDLE) ? bus.req_size  : r_size;
    assign w_src_addr  = (r_state == ST_IDLE) ? bus.req_addr  : r_addr;
    assign w_src_wdata = (r_state == ST_IDLE) ? bus.req_wdata : r_wdata;

    // 33-bit compare so the top of the window cannot wrap past 2^32.
    assign w_addr33   = {1'b0, w_src_addr};
    assign w_in_range = (w_addr33 >= LO_LIM) && (w_addr33 < HI_LIM);
    assign w_fault    = dmem_bad_align(w_src_size, w_src_addr[1:0]) | ~w_in_range;

    assign w_offset = w_src_addr - BASE_ADDR;
    assign w_index  = w_offset[AW+1:2];

    // A fault or a reset on the commit edge suppresses the write.
    assign w_ram_we    = (w_go_resp && w_src_we && !w_fault && !reset) ?
                         dmem_byte_en(w_src_size, w_src_addr[1:0]) : 4'b0000;
    assign w_ram_wdata = dmem_store_lanes(w_src_size, w_src_wdata);

    dmem_byte_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_go_resp & ~reset),
        .i_we    (w_ram_we),
        .i_addr  (w_index),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_size       <= SZ_BYTE;
            r_uns        <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_err        <= 1'b0;
            r_ready      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_we    <= bus.req_we;
                        r_size  <= bus.req_size;
                        r_uns   <= bus.req_unsigned;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_cnt   <= LAT_LOAD;
                        r_ready <= 1'b0;
                        if (LAT_ZERO) begin
                            r_state <= ST_RESP;
                            r_err   <= w_fault;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_RESP;
                        r_err   <= w_fault;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= r_err;
                    r_resp_rdata <= (r_err || r_we) ? 32'd0 :
                                    dmem_load(r_size, r_uns, r_addr[1:0], w_ram_rdata);
                    r_ready      <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_ready & ~reset;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
    assign o_state        = r_state;
endmodule
